// File: rtl/parking_gate_ctrl.sv
// Entry-gate controller: grants the barrier to a waiting car when the lot has room,
// times the open/close phases, and keeps capacity and error indications.
module parking_gate_ctrl #(
    parameter int unsigned CAPACITY  = 16,
    parameter int unsigned OPEN_CYC  = 8,
    parameter int unsigned CLOSE_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        enter,
    input  logic        exit,
    input  logic [31:0] cout,
    output logic        gate_open,
    output logic        full,
    output logic        empty,
    output logic        reject,
    output logic        timeout,
    output logic        intrusion,
    output logic        underflow,
    output logic [15:0] reject_cnt
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OCC_W   = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_CLOSING = 2'd2;
    localparam logic [1:0] ST_DENIED  = 2'd3;

    localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(OPEN_CYC - 1);
    localparam logic [TIMER_W-1:0] CLOSE_LOAD = TIMER_W'(CLOSE_CYC - 1);
    localparam logic [OCC_W-1:0]   CAP_EXT    = OCC_W'(CAPACITY);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               gate_open_q, gate_open_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               reject_q, reject_d;
    logic               timeout_q, timeout_d;
    logic               intrusion_q, intrusion_d;
    logic               underflow_q, underflow_d;
    logic [CNT_W-1:0]   reject_cnt_q, reject_cnt_d;

    logic room_c;
    logic occ_zero_c;
    logic timer_zero_c;

    assign room_c       = (cout < CAP_EXT);
    assign occ_zero_c   = (cout == '0);
    assign timer_zero_c = (timer_q == '0);

    // Next-state, timer and indication logic
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        reject_d     = 1'b0;
        timeout_d    = 1'b0;
        reject_cnt_d = reject_cnt_q;
        full_d       = ~room_c;
        empty_d      = occ_zero_c;
        intrusion_d  = intrusion_q | (enter & (state_q != ST_OPEN));
        underflow_d  = underflow_q | (exit & occ_zero_c);

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (room_c) begin
                        state_d = ST_OPEN;
                        timer_d = OPEN_LOAD;
                    end else begin
                        state_d  = ST_DENIED;
                        reject_d = 1'b1;
                        if (reject_cnt_q != CNT_MAX) begin
                            reject_cnt_d = reject_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_OPEN: begin
                // A car passing on the last open cycle is a normal entry, not a timeout
                if (enter) begin
                    state_d = ST_CLOSING;
                    timer_d = CLOSE_LOAD;
                end else if (timer_zero_c) begin
                    state_d   = ST_CLOSING;
                    timer_d   = CLOSE_LOAD;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_CLOSING: begin
                if (timer_zero_c) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_DENIED: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (room_c) begin
                    state_d = ST_OPEN;
                    timer_d = OPEN_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        gate_open_d = (state_d == ST_OPEN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            gate_open_q  <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            reject_q     <= 1'b0;
            timeout_q    <= 1'b0;
            intrusion_q  <= 1'b0;
            underflow_q  <= 1'b0;
            reject_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            gate_open_q  <= gate_open_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            reject_q     <= reject_d;
            timeout_q    <= timeout_d;
            intrusion_q  <= intrusion_d;
            underflow_q  <= underflow_d;
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign gate_open  = gate_open_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign reject     = reject_q;
    assign timeout    = timeout_q;
    assign intrusion  = intrusion_q;
    assign underflow  = underflow_q;
    assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: a cycle model pushes expected outputs as
// each input vector is driven; they are popped and compared after the clock edge.
module tb_parking_gate_ctrl;

    localparam int unsigned CAP   = 16;
    localparam int unsigned OPENC = 8;
    localparam int unsigned CLOSC = 4;

    typedef struct packed {
        logic        gate;
        logic        full;
        logic        empty;
        logic        rej;
        logic        to;
        logic        intr;
        logic        unf;
        logic [15:0] rcnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req;
    logic        enter;
    logic        exit;
    logic [31:0] cout;
    logic        gate_open;
    logic        full;
    logic        empty;
    logic        reject;
    logic        timeout;
    logic        intrusion;
    logic        underflow;
    logic [15:0] reject_cnt;

    parking_gate_ctrl #(.CAPACITY(CAP), .OPEN_CYC(OPENC), .CLOSE_CYC(CLOSC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .enter      (enter),
        .exit       (exit),
        .cout       (cout),
        .gate_open  (gate_open),
        .full       (full),
        .empty      (empty),
        .reject     (reject),
        .timeout    (timeout),
        .intrusion  (intrusion),
        .underflow  (underflow),
        .reject_cnt (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    // Reference model: up-counting phase age instead of a down-counting timer
    typedef enum int {M_IDLE, M_OPEN, M_CLOSING, M_DENIED} mstate_t;
    mstate_t m_state;
    int      m_age;
    exp_t    m_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_state = M_IDLE;
            m_age   = 0;
            m_out   = '0;
            m_out.empty = 1'b1;
        end else begin
            m_out.rej   = 1'b0;
            m_out.to    = 1'b0;
            m_out.full  = (cout >= 32'(CAP));
            m_out.empty = (cout == 32'd0);
            if (enter && m_state != M_OPEN) m_out.intr = 1'b1;
            if (exit && cout == 32'd0) m_out.unf = 1'b1;
            case (m_state)
                M_IDLE: if (req) begin
                    if (cout < 32'(CAP)) begin
                        m_state = M_OPEN;
                        m_age   = 0;
                    end else begin
                        m_state   = M_DENIED;
                        m_out.rej = 1'b1;
                        if (m_out.rcnt != 16'hFFFF) m_out.rcnt = m_out.rcnt + 16'd1;
                    end
                end
                M_OPEN: begin
                    if (enter) begin
                        m_state = M_CLOSING;
                        m_age   = 0;
                    end else if (m_age == int'(OPENC) - 1) begin
                        m_state  = M_CLOSING;
                        m_age    = 0;
                        m_out.to = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
                M_CLOSING: begin
                    if (m_age == int'(CLOSC) - 1) m_state = M_IDLE;
                    else m_age++;
                end
                M_DENIED: begin
                    if (!req) m_state = M_IDLE;
                    else if (cout < 32'(CAP)) begin
                        m_state = M_OPEN;
                        m_age   = 0;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
        m_out.gate = (m_state == M_OPEN);
    endtask

    // Drive one vector, push its expectation, compare after the edge
    task automatic step(input logic r, input logic rq, input logic en, input logic ex,
                        input logic [31:0] c);
        exp_t e;
        @(negedge clk);
        reset = r;
        req   = rq;
        enter = en;
        exit  = ex;
        cout  = c;
        model_step();
        sb_q.push_back(m_out);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            chk("gate_open",  32'(gate_open),  32'(e.gate));
            chk("full",       32'(full),       32'(e.full));
            chk("empty",      32'(empty),      32'(e.empty));
            chk("reject",     32'(reject),     32'(e.rej));
            chk("timeout",    32'(timeout),    32'(e.to));
            chk("intrusion",  32'(intrusion),  32'(e.intr));
            chk("underflow",  32'(underflow),  32'(e.unf));
            chk("reject_cnt", 32'(reject_cnt), 32'(e.rcnt));
        end
    endtask

    int n_high;
    int n_to;
    logic [31:0] occ_pick;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; req = 1'b0; enter = 1'b0; exit = 1'b0; cout = 32'd0;
        m_state = M_IDLE; m_age = 0; m_out = '0;

        // Reset state
        step(1, 0, 0, 0, 32'd0);
        step(1, 0, 0, 0, 32'd0);

        // Normal entry: enter three cycles after the gate rises
        step(0, 1, 0, 0, 32'd3);
        chk("grant_latency", 32'(gate_open), 32'd1);
        step(0, 1, 0, 0, 32'd3);
        step(0, 1, 0, 0, 32'd3);
        step(0, 0, 1, 0, 32'd3);
        chk("enter_closes", 32'(gate_open), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 32'd3);

        // Timeout: req held, no enter
        n_high = 0;
        n_to   = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 32'd0);
            if (gate_open) n_high++;
            if (timeout) n_to++;
        end
        chk("open_len", 32'(n_high), 32'(OPENC));
        chk("timeout_pulses", 32'(n_to), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 32'd0);

        // Full then space freed while req held
        step(0, 1, 0, 0, 32'd16);
        chk("reject_first", 32'(reject), 32'd1);
        step(0, 1, 0, 0, 32'd16);
        chk("reject_once", 32'(reject), 32'd0);
        step(0, 1, 0, 0, 32'd16);
        step(0, 1, 0, 0, 32'd15);
        chk("regrant_from_denied", 32'(gate_open), 32'd1);
        chk("reject_cnt_one", 32'(reject_cnt), 32'd1);
        step(0, 0, 1, 0, 32'd15);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 32'd16);

        // Error flags: enter in IDLE, exit while empty, cleared only by reset
        step(0, 0, 1, 0, 32'd4);
        step(0, 0, 0, 1, 32'd0);
        step(0, 0, 0, 0, 32'd7);
        chk("intrusion_sticky", 32'(intrusion), 32'd1);
        chk("underflow_sticky", 32'(underflow), 32'd1);
        step(1, 0, 0, 0, 32'd7);

        // Enter on the last open cycle wins over timeout
        step(0, 1, 0, 0, 32'd5);
        for (int i = 0; i < int'(OPENC) - 1; i++) step(0, 1, 0, 0, 32'd5);
        step(0, 0, 1, 0, 32'd5);
        chk("enter_wins_timeout", 32'(timeout), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 32'd5);

        // Reset while open, then a normal grant
        step(0, 1, 0, 0, 32'd2);
        step(0, 1, 0, 0, 32'd2);
        step(1, 1, 0, 0, 32'd2);
        chk("reset_drops_gate", 32'(gate_open), 32'd0);
        step(0, 1, 0, 0, 32'd2);
        chk("grant_after_reset", 32'(gate_open), 32'd1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 32'd2);

        // Random traffic including unsigned boundary occupancies
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0: occ_pick = 32'd0;
                1: occ_pick = 32'd15;
                2: occ_pick = 32'd16;
                3: occ_pick = 32'd17;
                4: occ_pick = 32'hFFFF_FFFF;
                5: occ_pick = 32'h8000_0000;
                default: occ_pick = 32'($urandom_range(1, 14));
            endcase
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 occ_pick);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Entry-gate controller for the parking-lot occupancy path. It sits directly downstream of the sensor FSM / occupancy counter pair and consumes their `enter` and `exit` pulses and 32-bit `cout` occupancy value. From those it decides whether the entry barrier may open for a waiting car, times the barrier, and raises capacity and error indications. All outputs are registered, with one clock of latency from the sampled inputs.

## Interface
- `CAPACITY`, 16: number of spaces; entry is refused when `cout >= CAPACITY`.
- `OPEN_CYC`, 8: maximum number of cycles the gate stays open waiting for an `enter` pulse.
- `CLOSE_CYC`, 4: number of cycles the gate needs to close; requests are ignored during this time.
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  level signal; a car is present at the entry loop.
- `enter`  in  1  one-cycle pulse from the sensor FSM: a car has passed inward.
- `exit`  in  1  one-cycle pulse from the sensor FSM: a car has passed outward.
- `cout`  in  32  current occupancy from the counter, unsigned.
- `gate_open`  out  1  barrier open command.
- `full`  out  1  high when `cout >= CAPACITY`.
- `empty`  out  1  high when `cout == 0`.
- `reject`  out  1  one-cycle pulse: a request was refused because the lot is full.
- `timeout`  out  1  one-cycle pulse: the gate closed with no `enter` seen.
- `intrusion`  out  1  sticky; set by an `enter` pulse while the FSM is not in OPEN.
- `underflow`  out  1  sticky; set by an `exit` pulse while `cout == 0`.
- `reject_cnt`  out  16  number of refusals, saturating at 16'hFFFF.

## Operation
- **State machine states:** IDLE, OPEN, CLOSING, DENIED.
- **IDLE**
  - `req=1` and `cout < CAPACITY`: go to OPEN and load the timer with `OPEN_CYC-1`.
  - `req=1` and `cout >= CAPACITY`: go to DENIED, pulse `reject`, and increment `reject_cnt` (saturating).
- **OPEN**
  - `gate_open=1`.
  - `enter=1`: go to CLOSING and load the timer with `CLOSE_CYC-1`.
  - Otherwise, timer reaching 0: go to CLOSING and pulse `timeout`.
  - If `enter` arrives on the timer-zero cycle, `enter` wins and no `timeout` pulse is issued.
- **CLOSING**
  - `gate_open=0`; `req` is ignored.
  - Timer reaching 0: go to IDLE.
- **DENIED**
  - `req=0`: go to IDLE.
  - `req=1` and `cout < CAPACITY`: go directly to OPEN (a space has freed up); no further `reject` pulse.
  - `req=1` with the lot still full: stay in DENIED; `reject` is not repeated.
- **Flags**
  - `full` and `empty` are registered compares of `cout`.
  - `cout` is compared as an unsigned 32-bit value against `CAPACITY` zero-extended to 32 bits.
- **Errors**
  - `intrusion` is set by `enter` in IDLE, CLOSING, or DENIED.
  - `underflow` is set by `exit` when `cout==0`.
  - Both are cleared only by `reset`.
- **Simultaneous events**
  - `enter` and `exit` in the same cycle are each evaluated independently with the rules above.
  - `exit` never affects the state machine.
- **Timer:** 16 bits wide. `OPEN_CYC` and `CLOSE_CYC` must each be ≥1.

## Timing
- **Reset values** (at the first edge with `reset=1`): state=IDLE, `gate_open=0`, `full=0`, `empty=1`, `reject=0`, `timeout=0`, `intrusion=0`, `underflow=0`, `reject_cnt=0`, timer=0.
- **Reset mid-operation:** `reset` asserted while OPEN drops `gate_open` at that same edge. There is no close sequence.
- **Gate latency:** `req` sampled high at edge N (room available) gives `gate_open=1` after edge N.
- **Open duration:** with no `enter`, `gate_open` stays high for exactly `OPEN_CYC` cycles.
  - `timeout` is high in the first cycle of CLOSING.
- **`enter` sampled at edge M while OPEN:** `gate_open=0` after edge M. The FSM returns to IDLE `CLOSE_CYC` cycles later.
- **Earliest re-grant:** the next grant can occur no earlier than `CLOSE_CYC+1` edges after `gate_open` falls.
- **`reject` timing:** high for exactly one cycle, in the same cycle the FSM first shows DENIED.
- **Flag latency:** `full`, `empty`, `intrusion`, and `underflow` lag their inputs by one cycle.

## Test plan
- **Normal entry:** reset; `cout=3`, raise `req`, pulse `enter` 3 cycles after `gate_open` rises → `gate_open` high for 3 cycles, then low; IDLE after a further 4 cycles; no `timeout`, no `intrusion`.
- **Timeout:** `cout=0`, hold `req` with no `enter` → `gate_open` high for exactly 8 cycles; `timeout` pulses once; `empty=1` throughout.
- **Full then space:** `cout=16`, `req=1` → `reject` pulses once, `reject_cnt=1`, `full=1`. Then drop `cout` to 15 with `req` still high → `gate_open=1` on the next cycle with no second `reject`.
- **Errors:** pulse `enter` in IDLE → `intrusion=1` and it stays set. Pulse `exit` with `cout=0` → `underflow=1`. Only `reset` clears both.
- **Enter on timeout cycle:** `enter` coincides with the 8th open cycle → CLOSING, `timeout` stays 0.
- **Reset mid-operation:** assert `reset` for 1 cycle while OPEN → `gate_open=0`, all outputs at reset values; a later `req` with `cout=2` grants normally.
